split_pipe: RTL and testbench

SPLIT_PIPE -- requirements
Module: split_pipe

---
 rtl/split_pipe.sv | 117 +++++++++++
 tb/tb_split_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_pipe.sv
// Two-stage constraint checker: NC lanes evaluate a per-lane operator, then an AND-reduce.
// Optional pass/total/fail statistics are built only when SPLIT_PIPE_STATS_EN is defined.
module split_pipe #(
  parameter int W  = 16,
  parameter int NC = 9,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NC*W-1:0] in_a,
  input  logic [NC*W-1:0] in_b,
  input  logic [2*NC-1:0] cfg_op,
  input  logic [NC*W-1:0] cfg_k,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_x,
  output logic [NC-1:0]   out_fail,
  input  logic            clr,
  output logic [CW-1:0]   pass_cnt,
  output logic [CW-1:0]   total_cnt,
  output logic [NC-1:0]   fail_mask
);

  function automatic logic lane_eval(input logic [1:0]   op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic [W-1:0] k);
    logic [W-1:0] sum;
    logic         res;
    sum = (a | k) + b;
    unique case (op)
      2'b00:   res = (a != k);
      2'b01:   res = |(a | b);
      2'b10:   res = (a != '0) && (b != '0);
      default: res = |sum;
    endcase
    return res;
  endfunction

  logic [NC-1:0] lane_res;
  logic [NC-1:0] s1_res;
  logic          s1_valid;
  logic          s1_adv;
  logic          s2_adv;

  always_comb begin
    lane_res = '0;
    for (int i = 0; i < NC; i++) begin
      lane_res[i] = lane_eval(cfg_op[2*i +: 2], in_a[i*W +: W], in_b[i*W +: W], cfg_k[i*W +: W]);
    end
  end

  // Backpressure is purely state-driven, so in_ready never loops through in_valid.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: stage-1 payload has no reset; s1_valid qualifies it, so only the valid bit needs one.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_res <= lane_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= 1'b0;
      out_fail  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_x    <= &s1_res;
        out_fail <= ~s1_res;
      end
    end
  end

`ifdef SPLIT_PIPE_STATS_EN
  logic xfer;
  assign xfer = out_valid && out_ready;

  // clr wins over a same-cycle transfer; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt  <= '0;
      total_cnt <= '0;
      fail_mask <= '0;
    end else if (clr) begin
      pass_cnt  <= '0;
      total_cnt <= '0;
      fail_mask <= '0;
    end else if (xfer) begin
      if (total_cnt != '1) total_cnt <= total_cnt + 1'b1;
      if (out_x && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
      fail_mask <= fail_mask | out_fail;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign pass_cnt   = '0;
  assign total_cnt  = '0;
  assign fail_mask  = '0;
`endif

endmodule

// File: tb/tb_split_pipe.sv
// Directed self-checking bench for split_pipe; a second instance with CW=2 shares the
// stimulus to exercise counter saturation. Statistics expectations follow SPLIT_PIPE_STATS_EN.
module tb_split_pipe;
  localparam int W  = 16;
  localparam int NC = 9;
`ifdef SPLIT_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            out_ready;
  logic            clr;
  logic [NC*W-1:0] in_a, in_b, cfg_k;
  logic [2*NC-1:0] cfg_op;

  logic            in_ready, out_valid, out_x;
  logic [NC-1:0]   out_fail, fail_mask;
  logic [15:0]     pass_cnt, total_cnt;

  logic            s_in_ready, s_out_valid, s_out_x;
  logic [NC-1:0]   s_out_fail, s_fail_mask;
  logic [1:0]      s_pass_cnt, s_total_cnt;

  int total = 0;
  int bad   = 0;

  split_pipe #(.W(W), .NC(NC), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cfg_op(cfg_op), .cfg_k(cfg_k),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_fail(out_fail),
    .clr(clr), .pass_cnt(pass_cnt), .total_cnt(total_cnt), .fail_mask(fail_mask)
  );

  split_pipe #(.W(W), .NC(NC), .CW(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .cfg_op(cfg_op), .cfg_k(cfg_k),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_x(s_out_x), .out_fail(s_out_fail),
    .clr(clr), .pass_cnt(s_pass_cnt), .total_cnt(s_total_cnt), .fail_mask(s_fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int tot, input int pas, input int mask);
    int st, sp;
    st = (tot > 3) ? 3 : tot;
    sp = (pas > 3) ? 3 : pas;
    check({tag, ".total"},   32'(total_cnt),   STATS ? tot  : 0);
    check({tag, ".pass"},    32'(pass_cnt),    STATS ? pas  : 0);
    check({tag, ".mask"},    32'(fail_mask),   STATS ? mask : 0);
    check({tag, ".s_total"}, 32'(s_total_cnt), STATS ? st   : 0);
    check({tag, ".s_pass"},  32'(s_pass_cnt),  STATS ? sp   : 0);
    check({tag, ".s_mask"},  32'(s_fail_mask), STATS ? mask : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] k);
    cfg_op[2*i +: 2] = op;
    in_a[i*W +: W]   = a;
    in_b[i*W +: W]   = b;
    cfg_k[i*W +: W]  = k;
  endtask

  task automatic set_pass_all();
    for (int i = 0; i < NC; i++) set_lane(i, 2'b01, 16'h0001, 16'h0000, 16'h0000);
  endtask

  // Candidate j fails only lane j (op 00 with a == k).
  task automatic load_cand(input int j);
    set_pass_all();
    set_lane(j, 2'b00, 16'h0055, 16'h0000, 16'h0055);
  endtask

  logic [NC-1:0] got [5];
  int            n_got;
  int            idx;
  int            ncyc;
  logic          acc;

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    in_a = '0; in_b = '0; cfg_k = '0; cfg_op = '0;
    #1 rst = 1'b1;
    #1;
    check("reset.in_ready",  32'(in_ready),  1);
    check("reset.out_valid", 32'(out_valid), 0);
    check("reset.out_x",     32'(out_x),     0);
    check("reset.out_fail",  32'(out_fail),  0);
    chk_stats("reset", 0, 0, 0);
    tick(); tick();
    rst = 1'b0;

    // Single passing candidate: all lanes op 01, a=1, b=0.
    set_pass_all();
    in_valid = 1'b1;
    #1;
    check("first.in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("first.lat1.out_valid", 32'(out_valid), 0);
    tick();
    check("first.lat2.out_valid", 32'(out_valid), 1);
    check("first.out_x",          32'(out_x),     1);
    check("first.out_fail",       32'(out_fail),  0);
    tick();
    check("first.drained", 32'(out_valid), 0);
    chk_stats("first", 1, 1, 0);

    // Lane 0 op 00 with a == k fails.
    set_pass_all();
    set_lane(0, 2'b00, 16'h14E8, 16'h0000, 16'h14E8);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("neq.out_valid", 32'(out_valid), 1);
    check("neq.out_x",     32'(out_x),     0);
    check("neq.out_fail",  32'(out_fail),  32'h001);
    tick();
    chk_stats("neq", 2, 1, 32'h001);

    // Mixed operators: lane3 wrap-to-zero fails, lane4 op01 zero fails, lane6 op10 b=0 fails.
    set_pass_all();
    set_lane(3, 2'b11, 16'h0000, 16'h0001, 16'hFFFF);
    set_lane(4, 2'b01, 16'h0000, 16'h0000, 16'h0000);
    set_lane(5, 2'b10, 16'h0003, 16'h0007, 16'h0000);
    set_lane(6, 2'b10, 16'h0003, 16'h0000, 16'h0000);
    set_lane(7, 2'b00, 16'h0005, 16'h0000, 16'h0006);
    set_lane(8, 2'b11, 16'h0001, 16'h0000, 16'h0002);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mix.out_valid", 32'(out_valid), 1);
    check("mix.out_x",     32'(out_x),     0);
    check("mix.out_fail",  32'(out_fail),  32'h058);
    tick();
    chk_stats("mix", 3, 1, 32'h059);

    // Stall: out_ready low, pipeline fills after two accepts.
    out_ready = 1'b0;
    load_cand(0);
    in_valid = 1'b1;
    #1;
    check("stall.rdy0", 32'(in_ready), 1);
    tick();
    load_cand(1);
    check("stall.rdy1", 32'(in_ready), 1);
    tick();
    load_cand(2);
    check("stall.rdy2", 32'(in_ready),  0);
    check("stall.ov2",  32'(out_valid), 1);
    check("stall.of2",  32'(out_fail),  32'h001);
    tick();
    check("stall.rdy3", 32'(in_ready),  0);
    check("stall.ov3",  32'(out_valid), 1);
    check("stall.of3",  32'(out_fail),  32'h001);
    check("stall.ox3",  32'(out_x),     0);

    // Release: collect the five results in order, one per cycle.
    idx = 2; n_got = 0; ncyc = 0;
    out_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 30 && n_got < 5; cyc++) begin
      if (idx < 5) begin
        load_cand(idx);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        got[n_got] = out_fail;
        n_got++;
      end
      tick();
      if (acc) idx++;
      ncyc++;
    end
    in_valid = 1'b0;
    check("stream.count",  32'(n_got), 5);
    check("stream.cycles", 32'(ncyc),  5);
    for (int i = 0; i < n_got; i++) check($sformatf("stream.res%0d", i), 32'(got[i]), 32'(1 << i));
    check("stream.no_dup", 32'(out_valid), 0);
    chk_stats("stream", 8, 1, 32'h05F);

    // Clear, then five passing transfers back to back.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_stats("clr", 0, 0, 0);
    set_pass_all();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b.rdy%0d", i), 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk_stats("sat", 5, 5, 0);

    // clr coinciding with a transfer: the transfer is not counted.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("clrx.out_valid", 32'(out_valid), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrx.consumed", 32'(out_valid), 0);
    chk_stats("clrx", 0, 0, 0);

    // Reset with two candidates in flight.
    out_ready = 1'b0;
    load_cand(1);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    check("inflight.out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(out_valid), 0);
    check("arst.out_fail",  32'(out_fail),  0);
    check("arst.in_ready",  32'(in_ready),  1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    load_cand(2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post.stale", 32'(out_valid), 0);
    tick();
    check("post.out_valid", 32'(out_valid), 1);
    check("post.out_fail",  32'(out_fail),  32'h004);
    tick();
    check("post.drained", 32'(out_valid), 0);
    chk_stats("post", 1, 0, 32'h004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
